cpu_control_fsm: RTL and testbench
==================================

Name: cpu_control_fsm

Overview:
- Multi-cycle control unit for the ARM-subset core; sits directly downstream of the instruction fetch stage.
- Consumes the latched IR and the condition-pass flag W_IR_valid.
- Drives every datapath enable: write_ir/write_pc/pc_s back to fetch, plus register-file, ALU, flag and data-memory controls.
- State register updates on posedge clk. Outputs are decoded from state and IR, so they are stable before the datapath's negedge sampling edge.

Parameters:
- MEM_TIMEOUT, 15, max cycles to wait for mem_ready before declaring a bus error (1..15; counter is 4 bits).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- IR  in  32  instruction latched by fetch
- W_IR_valid  in  1  condition-pass of the fetched instruction
- mem_ready  in  1  data-memory access complete
- write_ir  out  1  IR load enable
- write_pc  out  1  PC load enable
- pc_s  out  2  PC source: 00 PC+4, 01 branch target, 10 ALU result
- ld_ab  out  1  latch register operands A/B
- ld_c  out  1  latch ALU result
- alu_op  out  4  ALU operation
- write_flags  out  1  update NZCV
- rf_write  out  1  register-file write
- rf_wsel  out  1  write address: 0 = Rd (IR[15:12]), 1 = LR (r14)
- wb_sel  out  1  write data: 0 = ALU, 1 = memory
- mem_re  out  1  data read strobe
- mem_we  out  1  data write strobe
- undef  out  1  sticky: undefined instruction or bus timeout
- state_o  out  4  current state, for debug

Behaviour:
- Reset (rst low, asynchronous):
  - state = S_FETCH; undef = 0; timeout counter = 0.
  - All outputs not asserted by S_FETCH are 0.
- Instruction class from IR[27:25]:
  - 00x = data-processing (DP); opcode IR[24:21], S bit IR[20].
  - 010 = LDR/STR immediate; L bit IR[20], U bit IR[23].
  - 101 = B/BL; L bit IR[24].
  - Anything else = undefined.
- S_FETCH: write_ir = 1, write_pc = 1, pc_s = 00.
  - W_IR_valid = 1 -> S_DECODE.
  - W_IR_valid = 0: fetch has skipped the instruction and PC has already advanced; stay in S_FETCH. The failed instruction costs exactly 1 cycle.
- S_DECODE: ld_ab = 1. Next state by class: DP -> S_EXEC; mem -> S_ADDR; branch -> S_BRANCH; undefined -> S_HALT.
- S_EXEC: alu_op = IR[24:21]; ld_c = 1; write_flags = IR[20].
  - Compare opcodes (1000..1011) -> S_FETCH.
  - Otherwise -> S_WB.
- S_WB: rf_write = 1, rf_wsel = 0, wb_sel = 0.
  - If Rd == 15: rf_write = 0 instead, write_pc = 1, pc_s = 10.
  - Next state S_FETCH.
- S_ADDR: alu_op = 0100 (ADD) if U = 1, else 0010 (SUB); ld_c = 1. Next: L = 1 -> S_MEM_RD, L = 0 -> S_MEM_WR.
- S_MEM_RD / S_MEM_WR: hold mem_re or mem_we high continuously while waiting.
  - Counter increments each cycle that mem_ready = 0.
  - mem_ready = 1: MEM_RD -> S_LD_WB, MEM_WR -> S_FETCH; counter cleared.
  - Counter reaches MEM_TIMEOUT with mem_ready still 0 -> S_HALT.
  - mem_ready seen on the first cycle gives zero wait.
- S_LD_WB: rf_write = 1, wb_sel = 1, rf_wsel = 0. LDR to r15 is treated as undefined -> S_HALT, no write. Otherwise next S_FETCH.
- S_BRANCH: write_pc = 1, pc_s = 01; if L = 1, also rf_write = 1, rf_wsel = 1, wb_sel = 0 (ALU passes PC). Next S_FETCH.
- S_HALT: all enables 0; undef = 1 (sticky). Only reset exits.
- Cycle counts (fetch included):
  - Compare: 3. DP with writeback: 4.
  - Branch: 3. STR: 4 + wait cycles. LDR: 5 + wait cycles.
- Illegal state encodings go to S_HALT.
- Reset mid-access drops mem_re/mem_we asynchronously.

Decomposition:
- Shared package cpu_pkg holds:
  - state encodings: S_FETCH = 0, S_DECODE = 1, S_EXEC = 2, S_WB = 3, S_ADDR = 4, S_MEM_RD = 5, S_MEM_WR = 6, S_LD_WB = 7, S_BRANCH = 8, S_HALT = 15;
  - ALU opcode constants; instruction-class field positions; pc_s codes.
- One sub-module: cpu_instr_class, a combinational IR classifier (dp/mem/branch/undef, is_cmp, rd_is_pc).

Test Plan:
- Reset low mid-S_MEM_RD -> state_o = 0 and mem_re = 0 immediately. After release, first cycle is write_ir = 1, write_pc = 1, pc_s = 00.
- IR = 0xE0812003 (ADD r2,r1,r3) with W_IR_valid = 1 -> states 0,1,2,3,0.
  - S_EXEC: alu_op = 0100, write_flags = 0.
  - S_WB: rf_write = 1 with wb_sel = 0.
- IR = 0xE1510002 (CMP) -> states 0,1,2,0; write_flags = 1 in S_EXEC; no rf_write at any point.
- W_IR_valid = 0 for 3 cycles, then 1 -> state_o remains 0 with write_pc = 1 each cycle, then moves to S_DECODE.
- IR = 0xE5912004 (LDR) with mem_ready arriving after 2 wait cycles -> mem_re high for 3 cycles, then S_LD_WB with wb_sel = 1, rf_write = 1.
  - Repeat with mem_ready held 0 -> S_HALT after 15 cycles, undef = 1.
- IR = 0xEB000010 (BL) -> S_BRANCH: write_pc = 1, pc_s = 01, rf_write = 1, rf_wsel = 1.
  - IR = 0xE7000000 (undefined class) -> S_HALT, undef stays 1 until reset.

Source files
------------

// File: rtl/cpu_control_fsm_pkg.sv
// Shared definitions for the multi-cycle control unit: state encodings,
// ALU opcodes, PC source codes and instruction field positions.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_WB     = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_LD_WB  = 4'd7,
        S_BRANCH = 4'd8,
        S_HALT   = 4'd15
    } state_t;

    // ALU operations used by the address stage
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0100;

    // PC source select
    localparam logic [1:0] PC_S_INC = 2'b00;
    localparam logic [1:0] PC_S_BR  = 2'b01;
    localparam logic [1:0] PC_S_ALU = 2'b10;

    // Instruction field positions
    localparam int CLASS_HI = 27;
    localparam int CLASS_LO = 25;
    localparam int OPC_HI   = 24;
    localparam int OPC_LO   = 21;
    localparam int S_POS    = 20;
    localparam int L_POS    = 20;
    localparam int U_POS    = 23;
    localparam int LINK_POS = 24;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 12;

    localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Control bundle between the control unit and the fetch/datapath side.
// master = control unit, slave = datapath.
interface cpu_control_fsm_if;
    logic [31:0] IR;
    logic        W_IR_valid;
    logic        mem_ready;
    logic        write_ir;
    logic        write_pc;
    logic [1:0]  pc_s;
    logic        ld_ab;
    logic        ld_c;
    logic [3:0]  alu_op;
    logic        write_flags;
    logic        rf_write;
    logic        rf_wsel;
    logic        wb_sel;
    logic        mem_re;
    logic        mem_we;
    logic        undef;
    logic [3:0]  state_o;

    modport master (
        input  IR, W_IR_valid, mem_ready,
        output write_ir, write_pc, pc_s, ld_ab, ld_c, alu_op, write_flags,
               rf_write, rf_wsel, wb_sel, mem_re, mem_we, undef, state_o
    );

    modport slave (
        output IR, W_IR_valid, mem_ready,
        input  write_ir, write_pc, pc_s, ld_ab, ld_c, alu_op, write_flags,
               rf_write, rf_wsel, wb_sel, mem_re, mem_we, undef, state_o
    );
endinterface

// File: rtl/cpu_control_fsm_instr_class.sv
// Combinational IR classifier: instruction class plus the few fields the
// control FSM needs to steer its sequence.
module cpu_instr_class
    import cpu_pkg::*;
(
    input  logic [31:0] IR,
    output logic        is_dp,
    output logic        is_mem,
    output logic        is_branch,
    output logic        is_undef,
    output logic        is_cmp,
    output logic        rd_is_pc,
    output logic [3:0]  opcode,
    output logic        s_bit,
    output logic        load,
    output logic        up,
    output logic        link
);
    logic [2:0] cls;
    logic       unused_ir;

    // Decode class and control fields from the latched instruction
    always_comb begin
        cls       = IR[CLASS_HI:CLASS_LO];
        is_dp     = (cls[2:1] == 2'b00);
        is_mem    = (cls == 3'b010);
        is_branch = (cls == 3'b101);
        is_undef  = !(is_dp || is_mem || is_branch);
        opcode    = IR[OPC_HI:OPC_LO];
        is_cmp    = (opcode[3:2] == 2'b10);
        s_bit     = IR[S_POS];
        load      = IR[L_POS];
        up        = IR[U_POS];
        link      = IR[LINK_POS];
        rd_is_pc  = (IR[RD_HI:RD_LO] == REG_PC);
    end

    // Condition, Rn and operand2 fields are consumed by the datapath, not here
    assign unused_ir = ^{IR[31:28], IR[19:16], IR[11:0]};

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit for the ARM-subset core. Outputs are decoded from
// the current state and IR so they settle well before the datapath samples.
module cpu_control_fsm
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
)(
    input  logic               clk,
    input  logic               rst,
    cpu_control_fsm_if.master  bus
);
    localparam logic [3:0] TIMEOUT_LAST = 4'(MEM_TIMEOUT - 1);

    state_t     state, state_next;
    logic [3:0] wait_cnt, wait_cnt_next;
    logic       undef_q;

    logic       is_dp, is_mem, is_branch, is_undef, is_cmp, rd_is_pc;
    logic [3:0] opcode;
    logic       s_bit, load, up, link;

    logic       write_ir, write_pc, ld_ab, ld_c, write_flags;
    logic       rf_write, rf_wsel, wb_sel, mem_re, mem_we;
    logic [1:0] pc_s;
    logic [3:0] alu_op;

    cpu_instr_class u_class (
        .IR        (bus.IR),
        .is_dp     (is_dp),
        .is_mem    (is_mem),
        .is_branch (is_branch),
        .is_undef  (is_undef),
        .is_cmp    (is_cmp),
        .rd_is_pc  (rd_is_pc),
        .opcode    (opcode),
        .s_bit     (s_bit),
        .load      (load),
        .up        (up),
        .link      (link)
    );

    // State, memory-wait counter and sticky undefined flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_FETCH;
            wait_cnt <= 4'd0;
            undef_q  <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (state_next == S_HALT)
                undef_q <= 1'b1;
        end
    end

    // Next-state and datapath enable decode
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        write_ir      = 1'b0;
        write_pc      = 1'b0;
        pc_s          = PC_S_INC;
        ld_ab         = 1'b0;
        ld_c          = 1'b0;
        alu_op        = 4'd0;
        write_flags   = 1'b0;
        rf_write      = 1'b0;
        rf_wsel       = 1'b0;
        wb_sel        = 1'b0;
        mem_re        = 1'b0;
        mem_we        = 1'b0;

        case (state)
            S_FETCH: begin
                write_ir = 1'b1;
                write_pc = 1'b1;
                pc_s     = PC_S_INC;
                // A condition-failed instruction is skipped by fetch itself
                if (bus.W_IR_valid)
                    state_next = S_DECODE;
            end
            S_DECODE: begin
                ld_ab = 1'b1;
                if (is_undef)       state_next = S_HALT;
                else if (is_dp)     state_next = S_EXEC;
                else if (is_mem)    state_next = S_ADDR;
                else if (is_branch) state_next = S_BRANCH;
                else                state_next = S_HALT;
            end
            S_EXEC: begin
                alu_op      = opcode;
                ld_c        = 1'b1;
                write_flags = s_bit;
                state_next  = is_cmp ? S_FETCH : S_WB;
            end
            S_WB: begin
                // A result targeting r15 is a jump through the ALU
                if (rd_is_pc) begin
                    write_pc = 1'b1;
                    pc_s     = PC_S_ALU;
                end else begin
                    rf_write = 1'b1;
                end
                state_next = S_FETCH;
            end
            S_ADDR: begin
                alu_op     = up ? ALU_ADD : ALU_SUB;
                ld_c       = 1'b1;
                state_next = load ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD, S_MEM_WR: begin
                mem_re = (state == S_MEM_RD);
                mem_we = (state == S_MEM_WR);
                if (bus.mem_ready) begin
                    wait_cnt_next = 4'd0;
                    state_next    = (state == S_MEM_RD) ? S_LD_WB : S_FETCH;
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    wait_cnt_next = 4'd0;
                    state_next    = S_HALT;
                end else begin
                    wait_cnt_next = wait_cnt + 4'd1;
                end
            end
            S_LD_WB: begin
                wb_sel = 1'b1;
                // Loading the PC is not supported: trap instead of writing
                if (rd_is_pc) begin
                    state_next = S_HALT;
                end else begin
                    rf_write   = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_BRANCH: begin
                write_pc = 1'b1;
                pc_s     = PC_S_BR;
                if (link) begin
                    rf_write = 1'b1;
                    rf_wsel  = 1'b1;
                end
                state_next = S_FETCH;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_HALT;
            end
        endcase
    end

    assign bus.write_ir    = write_ir;
    assign bus.write_pc    = write_pc;
    assign bus.pc_s        = pc_s;
    assign bus.ld_ab       = ld_ab;
    assign bus.ld_c        = ld_c;
    assign bus.alu_op      = alu_op;
    assign bus.write_flags = write_flags;
    assign bus.rf_write    = rf_write;
    assign bus.rf_wsel     = rf_wsel;
    assign bus.wb_sel      = wb_sel;
    assign bus.mem_re      = mem_re;
    assign bus.mem_we      = mem_we;
    assign bus.undef       = undef_q;
    assign bus.state_o     = state;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: directed instructions plus random instruction
// streams, each checked cycle by cycle against a per-instruction trace model.
module tb_cpu_control_fsm;

    localparam int TIMEOUT = 15;

    logic clk;
    logic rst;

    cpu_control_fsm_if bus ();

    cpu_control_fsm #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One expected cycle: inputs to apply, then state and enables to observe
    typedef struct packed {
        logic       valid;
        logic       ready;
        logic [3:0] st;
        logic       wir;
        logic       wpc;
        logic [1:0] pcs;
        logic       ldab;
        logic       ldc;
        logic [3:0] aop;
        logic       wfl;
        logic       rfw;
        logic       rfs;
        logic       wbs;
        logic       mre;
        logic       mwe;
        logic       und;
    } cyc_t;

    cyc_t trace[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] dut_outs();
        return {bus.write_ir, bus.write_pc, bus.pc_s, bus.ld_ab, bus.ld_c,
                bus.alu_op, bus.write_flags, bus.rf_write, bus.rf_wsel,
                bus.wb_sel, bus.mem_re, bus.mem_we, bus.undef};
    endfunction

    function automatic cyc_t fetch_cycle(input logic valid);
        cyc_t c = '0;
        c.valid = valid;
        c.st    = 4'd0;
        c.wir   = 1'b1;
        c.wpc   = 1'b1;
        return c;
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction, from its class rules
    task automatic build(input logic [31:0] ir, input int skips, input int waits,
                         input bit hang, output bit halted);
        cyc_t       c;
        logic [2:0] cls  = ir[27:25];
        logic [3:0] opc  = ir[24:21];
        logic [3:0] rd   = ir[15:12];
        bit         halt = 0;
        trace.delete();
        for (int i = 0; i < skips; i++) trace.push_back(fetch_cycle(1'b0));
        trace.push_back(fetch_cycle(1'b1));
        c = '0; c.st = 4'd1; c.ldab = 1'b1; trace.push_back(c);
        if (cls[2:1] == 2'b00) begin
            c = '0; c.st = 4'd2; c.aop = opc; c.ldc = 1'b1; c.wfl = ir[20];
            trace.push_back(c);
            if (!(opc >= 4'd8 && opc <= 4'd11)) begin
                c = '0; c.st = 4'd3;
                if (rd == 4'd15) begin c.wpc = 1'b1; c.pcs = 2'd2; end
                else c.rfw = 1'b1;
                trace.push_back(c);
            end
        end else if (cls == 3'b010) begin
            c = '0; c.st = 4'd4; c.aop = ir[23] ? 4'd4 : 4'd2; c.ldc = 1'b1;
            trace.push_back(c);
            c = '0; c.st = ir[20] ? 4'd5 : 4'd6; c.mre = ir[20]; c.mwe = !ir[20];
            if (hang) begin
                for (int i = 0; i < TIMEOUT; i++) trace.push_back(c);
                halt = 1;
            end else begin
                for (int i = 0; i < waits; i++) trace.push_back(c);
                c.ready = 1'b1;
                trace.push_back(c);
                if (ir[20]) begin
                    c = '0; c.st = 4'd7; c.wbs = 1'b1; c.rfw = (rd != 4'd15);
                    trace.push_back(c);
                    if (rd == 4'd15) halt = 1;
                end
            end
        end else if (cls == 3'b101) begin
            c = '0; c.st = 4'd8; c.wpc = 1'b1; c.pcs = 2'd1;
            c.rfw = ir[24]; c.rfs = ir[24];
            trace.push_back(c);
        end else begin
            halt = 1;
        end
        if (halt) begin
            c = '0; c.st = 4'd15; c.und = 1'b1;
            for (int i = 0; i < 3; i++) trace.push_back(c);
        end
        halted = halt;
    endtask

    // Replay up to nmax cycles of the trace against the DUT
    task automatic run_trace(input string name, input logic [31:0] ir, input int nmax);
        for (int i = 0; i < trace.size() && i < nmax; i++) begin
            @(negedge clk);
            if (i == 0) bus.IR = ir;
            bus.W_IR_valid = trace[i].valid;
            bus.mem_ready  = trace[i].ready;
            #1;
            check($sformatf("%s c%0d state", name, i), 32'(bus.state_o), 32'(trace[i].st));
            check($sformatf("%s c%0d outs", name, i), 32'(dut_outs()), 32'(trace[i][16:0]));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.W_IR_valid = 1'b0;
        bus.mem_ready  = 1'b0;
        rst = 1'b0;
        #1;
        check("rst state", 32'(bus.state_o), 32'd0);
        check("rst outs", 32'(dut_outs()), 32'(fetch_cycle(1'b0) & 23'h1FFFF));
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic do_instr(input string name, input logic [31:0] ir, input int skips,
                            input int waits, input bit hang);
        bit halted;
        build(ir, skips, waits, hang, halted);
        run_trace(name, ir, trace.size());
        if (halted) do_reset();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ir = $urandom;
        int          k  = $urandom_range(0, 5);
        ir[31:28] = 4'hE;
        case (k)
            0, 1: begin
                ir[27:26] = 2'b00;
                if ($urandom_range(0, 2) == 0) ir[24:23] = 2'b10;
            end
            2, 3: ir[27:25] = 3'b010;
            4:    ir[27:25] = 3'b101;
            default: begin
                case ($urandom_range(0, 2))
                    0: ir[27:25] = 3'b011;
                    1: ir[27:25] = 3'b110;
                    default: ir[27:25] = 3'b111;
                endcase
            end
        endcase
        if ($urandom_range(0, 7) == 0) ir[15:12] = 4'hF;
        return ir;
    endfunction

    initial begin
        bit halted;
        rst            = 1'b0;
        bus.IR         = 32'h0;
        bus.W_IR_valid = 1'b0;
        bus.mem_ready  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset state", 32'(bus.state_o), 32'd0);
        check("reset undef", 32'(bus.undef), 32'd0);
        check("reset outs", 32'(dut_outs()), 32'(fetch_cycle(1'b0) & 23'h1FFFF));
        @(negedge clk);
        rst = 1'b1;

        do_instr("add", 32'hE0812003, 0, 0, 0);
        do_instr("cmp", 32'hE1510002, 0, 0, 0);
        do_instr("skip3", 32'hE0812003, 3, 0, 0);
        do_instr("ldr_w2", 32'hE5912004, 0, 2, 0);
        do_instr("ldr_w0", 32'hE5912004, 0, 0, 0);
        do_instr("str_w14", 32'hE5812004, 0, 14, 0);
        do_instr("ldr_hang", 32'hE5912004, 0, 0, 1);
        do_instr("bl", 32'hEB000010, 0, 0, 0);
        do_instr("b", 32'hEA000010, 0, 0, 0);
        do_instr("undef", 32'hE7000000, 0, 0, 0);
        do_instr("mov_pc", 32'hE1A0F002, 0, 0, 0);
        do_instr("ldr_pc", 32'hE591F004, 0, 1, 0);

        // Reset asserted while a load is waiting on memory
        build(32'hE5912004, 0, 10, 0, halted);
        run_trace("ldr_rst", 32'hE5912004, 5);
        #2;
        bus.W_IR_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst state", 32'(bus.state_o), 32'd0);
        check("midrst mem_re", 32'(bus.mem_re), 32'd0);
        check("midrst outs", 32'(dut_outs()), 32'(fetch_cycle(1'b0) & 23'h1FFFF));
        @(negedge clk);
        rst = 1'b1;
        do_instr("post_rst", 32'hE0812003, 0, 0, 0);

        for (int n = 0; n < 250; n++) begin
            logic [31:0] ir = rand_instr();
            do_instr($sformatf("rnd%0d", n), ir, $urandom_range(0, 2),
                     $urandom_range(0, TIMEOUT - 1), ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
